// File: rtl/wb_reg_responder_pkg.sv
// Shared definitions for the Wishbone register responder.
// Holds the responder FSM state encoding, the CTRL/STAT register offsets
// (the two topmost register indices), and the IE/IF bit positions.
package wb_pkg_hdl;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_ACK  = 2'd2
  } wb_state_e;

  localparam int IE_BIT = 0;
  localparam int IF_BIT = 0;

  // CTRL is the second-highest register index.
  function automatic int ctrl_offset(input int adr_w);
    return (1 << adr_w) - 2;
  endfunction

  // STAT is the highest register index.
  function automatic int stat_offset(input int adr_w);
    return (1 << adr_w) - 1;
  endfunction

endpackage

// File: rtl/wb_reg_responder_if.sv
// Wishbone classic bus bundle between an initiator and the register responder.
// Signals: cyc, stb, adr, we and toSLV_dat come from the initiator.
// fromSLV_dat, ack and inta come from the responder.
// The master modport is the initiator view; the slave modport is the responder view.
interface wb_interface #(
  parameter int ADR_W = 2,
  parameter int DAT_W = 8
);
  logic             cyc;
  logic             stb;
  logic [ADR_W-1:0] adr;
  logic             we;
  logic [DAT_W-1:0] toSLV_dat;
  logic [DAT_W-1:0] fromSLV_dat;
  logic             ack;
  logic             inta;

  modport master (
    output cyc, stb, adr, we, toSLV_dat,
    input  fromSLV_dat, ack, inta
  );

  modport slave (
    input  cyc, stb, adr, we, toSLV_dat,
    output fromSLV_dat, ack, inta
  );
endinterface

// File: rtl/wb_reg_responder_fsm.sv
// Transfer sequencer for the register responder.
// It holds the IDLE/WAIT/ACK state, the wait-state counter and the registered ack.
// Ports:
//   sys_clk, sys_rst  clock and synchronous active-high reset
//   cyc, stb          bus request
//   ack               registered single-cycle acknowledge
//   capture           request accepted this cycle (IDLE exit); latch adr/we/data
//   ack_entry         the next edge enters ACK; load the read data
//   commit            in ACK; the write takes effect at the end of this cycle
module wb_resp_fsm
  import wb_pkg_hdl::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic cyc,
  input  logic stb,
  output logic ack,
  output logic capture,
  output logic ack_entry,
  output logic commit
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_state_e  state_r;
  wb_state_e  state_next_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_next_s;
  logic       ack_r;

  assign ack    = ack_r;
  assign commit = (state_r == WB_ACK);

  // Next-state, wait-counter and strobe decode.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    capture      = 1'b0;
    ack_entry    = 1'b0;
    case (state_r)
      WB_IDLE: begin
        if (cyc && stb) begin
          capture = 1'b1;
          if (WAIT_STATES > 0) begin
            state_next_s = WB_WAIT;
            cnt_next_s   = WAIT_LOAD;
          end else begin
            state_next_s = WB_ACK;
            ack_entry    = 1'b1;
          end
        end else begin
          state_next_s = WB_IDLE;
        end
      end
      WB_WAIT: begin
        // Abort leaves nothing behind: the captured request is simply never committed.
        if (!cyc || !stb) begin
          state_next_s = WB_IDLE;
        end else if (cnt_r == 4'd0) begin
          state_next_s = WB_ACK;
          ack_entry    = 1'b1;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      WB_ACK: begin
        // Always return through IDLE so a held strobe cannot re-acknowledge back to back.
        state_next_s = WB_IDLE;
      end
      default: begin
        state_next_s = WB_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // State, counter and ack registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= WB_IDLE;
      cnt_r   <= 4'd0;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ack_r   <= ack_entry;
    end
  end

endmodule

// File: rtl/wb_reg_responder.sv
// Wishbone classic register responder.
// Registers 0..N-3 are scratch registers. N-2 is CTRL, whose bit 0 is IE.
// N-1 is STAT: bit 0 is IF (write 1 to clear), and the upper bits are WCNT, the count of scratch writes.
// Ports:
//   sys_clk, sys_rst  clock and synchronous active-high reset
//   bus               wb_interface slave view; inta = IE & IF (registered)

// Parameter range guard, evaluated at elaboration.
module wb_reg_responder_param_chk #(
  parameter int ADR_W       = 2,
  parameter int DAT_W       = 8,
  parameter int WAIT_STATES = 0
);
  if (ADR_W < 2) begin : g_bad_adr_w
    $error("wb_reg_responder: ADR_W must be >= 2");
  end
  if (DAT_W < 2) begin : g_bad_dat_w
    $error("wb_reg_responder: DAT_W must be >= 2");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("wb_reg_responder: WAIT_STATES must be 0..15");
  end
endmodule

module wb_reg_responder
  import wb_pkg_hdl::*;
#(
  parameter int ADR_W       = 2,
  parameter int DAT_W       = 8,
  parameter int WAIT_STATES = 0
) (
  input logic        sys_clk,
  input logic        sys_rst,
  wb_interface.slave bus
);

  localparam int N = 1 << ADR_W;
  localparam logic [ADR_W-1:0] CTRL_ADR = ADR_W'(ctrl_offset(ADR_W));
  localparam logic [ADR_W-1:0] STAT_ADR = ADR_W'(stat_offset(ADR_W));

  logic             ack_s;
  logic             capture_s;
  logic             ack_entry_s;
  logic             commit_s;

  logic [ADR_W-1:0] cap_adr_r;
  logic [DAT_W-1:0] cap_dat_r;
  logic             cap_we_r;

  logic [DAT_W-1:0] scratch_r [0:N-3];
  logic             ie_r;
  logic             if_r;
  logic [DAT_W-2:0] wcnt_r;
  logic             inta_r;
  logic [DAT_W-1:0] rdata_r;

  logic [ADR_W-1:0] rd_adr_s;
  logic [DAT_W-1:0] rd_mux_s;
  logic             wr_s;
  logic             wr_scr_s;
  logic             ie_next_s;
  logic             if_next_s;
  logic [DAT_W-2:0] wcnt_next_s;

  wb_reg_responder_param_chk #(
    .ADR_W      (ADR_W),
    .DAT_W      (DAT_W),
    .WAIT_STATES(WAIT_STATES)
  ) u_param_chk ();

  wb_resp_fsm #(
    .WAIT_STATES(WAIT_STATES)
  ) u_fsm (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .cyc      (bus.cyc),
    .stb      (bus.stb),
    .ack      (ack_s),
    .capture  (capture_s),
    .ack_entry(ack_entry_s),
    .commit   (commit_s)
  );

  assign bus.ack         = ack_s;
  assign bus.fromSLV_dat = rdata_r;
  assign bus.inta        = inta_r;

  // Read mux. With no wait states, ACK is entered on the capture edge, so the live bus address is used then.
  always_comb begin
    rd_adr_s = capture_s ? bus.adr : cap_adr_r;
    rd_mux_s = '0;
    if (rd_adr_s == STAT_ADR) begin
      rd_mux_s = {wcnt_r, if_r};
    end else if (rd_adr_s == CTRL_ADR) begin
      rd_mux_s[IE_BIT] = ie_r;
    end else begin
      for (int i = 0; i < N - 2; i++) begin
        rd_mux_s = (rd_adr_s == ADR_W'(i)) ? scratch_r[i] : rd_mux_s;
      end
    end
  end

  // Next values of IE, IF and WCNT for a committing write.
  always_comb begin
    wr_s        = commit_s && cap_we_r;
    wr_scr_s    = 1'b0;
    ie_next_s   = ie_r;
    if_next_s   = if_r;
    wcnt_next_s = wcnt_r;
    if (wr_s) begin
      if (cap_adr_r == CTRL_ADR) begin
        ie_next_s = cap_dat_r[IE_BIT];
      end else if (cap_adr_r == STAT_ADR) begin
        // Only a 1 in bit 0 clears IF; the WCNT bits of the write data are ignored.
        if (cap_dat_r[IF_BIT]) begin
          if_next_s = 1'b0;
        end else begin
          if_next_s = if_r;
        end
      end else begin
        wr_scr_s    = 1'b1;
        if_next_s   = 1'b1;
        wcnt_next_s = wcnt_r + (DAT_W-1)'(1);
      end
    end else begin
      wr_scr_s = 1'b0;
    end
  end

  // Request capture, register bank, status and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cap_adr_r <= '0;
      cap_dat_r <= '0;
      cap_we_r  <= 1'b0;
      ie_r      <= 1'b0;
      if_r      <= 1'b0;
      wcnt_r    <= '0;
      inta_r    <= 1'b0;
      rdata_r   <= '0;
      for (int i = 0; i < N - 2; i++) begin
        scratch_r[i] <= '0;
      end
    end else begin
      if (capture_s) begin
        cap_adr_r <= bus.adr;
        cap_dat_r <= bus.toSLV_dat;
        cap_we_r  <= bus.we;
      end
      rdata_r <= ack_entry_s ? rd_mux_s : '0;
      ie_r    <= ie_next_s;
      if_r    <= if_next_s;
      wcnt_r  <= wcnt_next_s;
      // Computed from the next values, so inta follows the committing edge by one cycle, not two.
      inta_r  <= ie_next_s & if_next_s;
      for (int i = 0; i < N - 2; i++) begin
        if (wr_scr_s && (cap_adr_r == ADR_W'(i))) begin
          scratch_r[i] <= cap_dat_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_reg_responder.sv
// Directed self-checking bench for wb_reg_responder.
// There are two instances: dut0 has no wait states and dut3 has three wait states.
module tb_wb_reg_responder;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  wb_interface #(.ADR_W(2), .DAT_W(8)) bus0 ();
  wb_interface #(.ADR_W(2), .DAT_W(8)) bus3 ();

  wb_reg_responder #(.ADR_W(2), .DAT_W(8), .WAIT_STATES(0)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus0)
  );
  wb_reg_responder #(.ADR_W(2), .DAT_W(8), .WAIT_STATES(3)) dut3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus3)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input int sel, input logic c, input logic s, input logic w,
                     input logic [1:0] a, input logic [7:0] d);
    if (sel == 0) begin
      bus0.cyc = c; bus0.stb = s; bus0.we = w; bus0.adr = a; bus0.toSLV_dat = d;
    end else begin
      bus3.cyc = c; bus3.stb = s; bus3.we = w; bus3.adr = a; bus3.toSLV_dat = d;
    end
  endtask

  function automatic logic get_ack(input int sel);
    return (sel == 0) ? bus0.ack : bus3.ack;
  endfunction

  function automatic logic [7:0] get_dat(input int sel);
    return (sel == 0) ? bus0.fromSLV_dat : bus3.fromSLV_dat;
  endfunction

  function automatic logic get_inta(input int sel);
    return (sel == 0) ? bus0.inta : bus3.inta;
  endfunction

  // One transfer. It returns one cycle after the ack cycle, with the FSM back in IDLE.
  task automatic xfer(input int sel, input logic w, input logic [1:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output int lat, output logic ia);
    lat = 0; rd = 8'h00; ia = 1'b0;
    drv(sel, 1'b1, 1'b1, w, a, d);
    for (int i = 1; i <= 30; i++) begin
      @(posedge sys_clk); #1;
      if (get_ack(sel)) begin
        lat = i; rd = get_dat(sel); ia = get_inta(sel);
        break;
      end
    end
    drv(sel, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    if (lat == 0) chk_eq("ack_timeout", 32'd0, 32'd1);
    @(posedge sys_clk); #1;
  endtask

  task automatic wr(input int sel, input logic [1:0] a, input logic [7:0] d);
    logic [7:0] rd; int lat; logic ia;
    xfer(sel, 1'b1, a, d, rd, lat, ia);
    chk_eq("wr_latency", lat, (sel == 0) ? 32'd1 : 32'd4);
  endtask

  task automatic rd_chk(input int sel, input logic [1:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] rd; int lat; logic ia;
    xfer(sel, 1'b0, a, 8'h00, rd, lat, ia);
    chk_eq(tag, rd, exp);
    chk_eq("rd_latency", lat, (sel == 0) ? 32'd1 : 32'd4);
    chk_eq("dat_zero_idle", get_dat(sel), 8'h00);
  endtask

  initial begin
    logic [7:0] rd;
    int         lat;
    logic       ia;
    int         n_ack;

    drv(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    drv(3, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    repeat (3) @(posedge sys_clk);
    #1;
    chk_eq("rst_ack0", bus0.ack, 1'b0);
    chk_eq("rst_dat0", bus0.fromSLV_dat, 8'h00);
    chk_eq("rst_inta0", bus0.inta, 1'b0);
    chk_eq("rst_ack3", bus3.ack, 1'b0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // Basic write and read-back with no wait states.
    wr(0, 2'd0, 8'hA5);
    rd_chk(0, 2'd0, 8'hA5, "rd_reg0");
    rd_chk(0, 2'd3, 8'h03, "stat_after_wr");
    chk_eq("inta_masked", bus0.inta, 1'b0);

    // Interrupt enable, set and clear.
    wr(0, 2'd3, 8'h01);
    rd_chk(0, 2'd3, 8'h02, "stat_if_clr");
    wr(0, 2'd2, 8'hFF);
    rd_chk(0, 2'd2, 8'h01, "ctrl_ie_only");
    chk_eq("inta_no_if", bus0.inta, 1'b0);
    xfer(0, 1'b1, 2'd1, 8'h3C, rd, lat, ia);
    chk_eq("inta_at_ack", ia, 1'b0);
    chk_eq("inta_rise", bus0.inta, 1'b1);
    wr(0, 2'd3, 8'h01);
    chk_eq("inta_fall", bus0.inta, 1'b0);
    rd_chk(0, 2'd3, 8'h04, "stat_wcnt2");
    wr(0, 2'd1, 8'h3D);
    chk_eq("inta_again", bus0.inta, 1'b1);
    wr(0, 2'd2, 8'h00);
    chk_eq("inta_ie_off", bus0.inta, 1'b0);
    rd_chk(0, 2'd3, 8'h07, "stat_if_kept");

    // WCNT wraps to 0 at the 128th scratch write.
    for (int i = 1; i <= 125; i++) begin
      xfer(0, 1'b1, 2'd1, 8'(i), rd, lat, ia);
    end
    rd_chk(0, 2'd3, 8'h01, "wcnt_wrap");
    wr(0, 2'd3, 8'hFE);
    rd_chk(0, 2'd3, 8'h01, "stat_fe_noop");
    rd_chk(0, 2'd1, 8'h7D, "rd_reg1_last");
    rd_chk(0, 2'd0, 8'hA5, "rd_reg0_kept");

    // A strobe held high across ack gives one ack every two cycles.
    n_ack = 0;
    drv(0, 1'b1, 1'b1, 1'b1, 2'd0, 8'h11);
    for (int i = 0; i < 12; i++) begin
      @(posedge sys_clk); #1;
      if (bus0.ack) n_ack++;
    end
    drv(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    chk_eq("held_acks_ws0", n_ack, 32'd6);
    @(posedge sys_clk); #1;
    rd_chk(0, 2'd3, 8'h0D, "held_commits");
    rd_chk(0, 2'd0, 8'h11, "held_data");

    // Three wait states.
    rd_chk(3, 2'd0, 8'h00, "ws3_rd_init");
    wr(3, 2'd0, 8'h5A);
    drv(3, 1'b1, 1'b1, 1'b1, 2'd0, 8'hFF);
    repeat (2) begin @(posedge sys_clk); #1; end
    drv(3, 1'b1, 1'b0, 1'b1, 2'd0, 8'hFF);
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge sys_clk); #1;
      if (bus3.ack) n_ack++;
    end
    drv(3, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    chk_eq("abort_no_ack", n_ack, 32'd0);
    rd_chk(3, 2'd0, 8'h5A, "abort_no_write");
    rd_chk(3, 2'd3, 8'h03, "ws3_stat");

    n_ack = 0;
    drv(3, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(posedge sys_clk); #1;
      if (bus3.ack) n_ack++;
    end
    drv(3, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    chk_eq("held_acks_ws3", n_ack, 32'd2);
    @(posedge sys_clk); #1;

    // Reset during WAIT of a write.
    drv(3, 1'b1, 1'b1, 1'b1, 2'd1, 8'h77);
    repeat (2) begin @(posedge sys_clk); #1; end
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    chk_eq("rst_wait_ack", bus3.ack, 1'b0);
    chk_eq("rst_wait_dat", bus3.fromSLV_dat, 8'h00);
    chk_eq("rst_wait_inta", bus3.inta, 1'b0);
    sys_rst = 1'b0;
    drv(3, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    @(posedge sys_clk); #1;
    rd_chk(3, 2'd1, 8'h00, "rst_no_commit");
    rd_chk(3, 2'd3, 8'h00, "rst_stat_clear");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_reg_responder.md
# wb_reg_responder

Parametrised Wishbone classic responder: a register bank with configurable width, depth and wait-state latency, plus a maskable interrupt and a write-event counter. It plugs onto the responder side of the `wb_interface` bus used by the wb2spi environment. It serves as a synthesizable stand-in target for initiator bring-up and as the next-generation replacement for fixed 2-bit/8-bit responders.

## Interface
Parameters:
- `ADR_W`, 2, address width; register count `N = 2**ADR_W`; must be ≥ 2.
- `DAT_W`, 8, data width; must be ≥ 2.
- `WAIT_STATES`, 0, extra cycles inserted before `ack`; range 0..15.

Ports:
- `sys_clk`  in  1  clock; all logic on the rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `cyc`  in  1  bus cycle valid.
- `stb`  in  1  strobe.
- `adr`  in  ADR_W  register index.
- `we`  in  1  1 = write, 0 = read.
- `toSLV_dat`  in  DAT_W  write data.
- `fromSLV_dat`  out  DAT_W  read data; valid only while `ack` = 1, else 0.
- `ack`  out  1  single-cycle acknowledge.
- `inta`  out  1  interrupt, level, `= IE & IF`.

## Operation
- Register map:
  - `0..N-3`: SCRATCH, read/write, reset 0.
  - `N-2`: CTRL. Bit0 = IE. Other bits read 0 and ignore writes.
  - `N-1`: STAT. Bit0 = IF, write-1-to-clear. Bits `DAT_W-1:1` = WCNT, read-only.
- WCNT counts completed SCRATCH writes modulo `2**(DAT_W-1)`; it wraps from all-ones to 0.
- IF sets on every completed SCRATCH write. CTRL and STAT writes never set IF.
- FSM states:
  - IDLE: `cyc & stb` → WAIT if `WAIT_STATES > 0`, else ACK. The wait counter loads `WAIT_STATES-1` on entry to WAIT.
  - WAIT: if `!cyc | !stb`, abort → IDLE with no side effect. Else counter = 0 → ACK; otherwise decrement.
  - ACK: `ack` = 1 for exactly this cycle; always → IDLE.
- Commit: the write takes effect (register, IF, WCNT) at the clock edge ending the ACK cycle.
  - Address, data and `we` are captured at the IDLE exit edge; later bus changes are ignored.
- Read data is registered from the captured address at ACK entry and driven only during ACK.
- Abort with `cyc` low in IDLE or WAIT: no `ack` and no state change.
  - If `cyc` drops during the ACK cycle, the transfer still commits; the initiator is responsible for holding the request.
- STAT write with bit0 = 1 clears IF; bit0 = 0 leaves IF unchanged. WCNT bits in the write data are ignored.
- IE = 0 masks `inta` without affecting IF.

## Timing
- Reset: state IDLE; all registers, IF, IE, WCNT = 0; `ack` = 0; `fromSLV_dat` = 0; `inta` = 0.
- Request first sampled high at edge k → `ack` high in cycle k+1+WAIT_STATES (registered, zero-combinational path from inputs).
- After ACK, the FSM always spends ≥1 IDLE cycle, so `stb` held high after `ack` never double-acks.
  - Throughput: one transfer per `WAIT_STATES+2` cycles.
- `inta` is registered; it rises the cycle after the committing edge of a SCRATCH write with IE = 1.
- Same-edge IF clear and IF set cannot occur (single port). Same-edge IE write and IF set cannot occur either.
- Reset asserted mid-WAIT or in ACK: returns to IDLE next edge, no commit, `ack` = 0.

## Structure
- Shared package `wb_pkg_hdl`: FSM state enum (`WB_IDLE`, `WB_WAIT`, `WB_ACK`), CTRL/STAT offset constants (`N-2`, `N-1` expressed as functions of `ADR_W`), and IE/IF bit-position constants.
- One sub-module: `wb_resp_fsm` (state register, wait counter, `ack`, commit strobe). The top level holds the register bank, IF/IE/WCNT and read mux.
- Elaboration-time assertions enforce the parameter ranges.

## Test plan
- `ADR_W=2, DAT_W=8, WAIT_STATES=0`: write 0xA5 to reg 0, then read reg 0 → `ack` one cycle after each request; read returns 0xA5; STAT reads 0x03 (WCNT=1, IF=1).
- `WAIT_STATES=3`: read request held → `ack` exactly 4 cycles after first sample; drop `stb` after 2 cycles → no `ack`, reg unchanged.
- Write CTRL = 0x01, then SCRATCH write → `inta` rises one cycle after `ack`. Write STAT = 0x01 → `inta` and IF fall. Write CTRL = 0x00 with IF set → `inta` = 0 and STAT bit0 = 1.
- 128 SCRATCH writes with `DAT_W=8` → WCNT wraps to 0; write STAT = 0xFE → WCNT unchanged, IF unchanged.
- `stb` held high across `ack` → exactly one `ack` per `WAIT_STATES+2` cycles; no duplicate commit.
- Assert `sys_rst` during WAIT of a write → no `ack`, target reg stays 0, all outputs 0 next cycle.
